// File: rtl/xpt_cfg_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xpt_cfg_parser_if : Ethernet header + payload stream into the cfg parser  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface xpt_cfg_parser_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
);
    logic                  s_eth_hdr_valid;
    logic                  s_eth_hdr_ready;
    logic [47:0]           s_eth_dest_mac;
    logic [47:0]           s_eth_src_mac;
    logic [15:0]           s_eth_type;
    logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep;
    logic                  s_eth_payload_axis_tvalid;
    logic                  s_eth_payload_axis_tready;
    logic                  s_eth_payload_axis_tlast;
    logic                  s_eth_payload_axis_tuser;

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
        output s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast,
        output s_eth_payload_axis_tuser,
        input  s_eth_hdr_ready, s_eth_payload_axis_tready
    );

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep,
        input  s_eth_payload_axis_tvalid, s_eth_payload_axis_tlast,
        input  s_eth_payload_axis_tuser,
        output s_eth_hdr_ready, s_eth_payload_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/xpt_cfg_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xpt_cfg_parser : validates config frames, commits crosspoint map atomically|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module xpt_cfg_parser #(
    parameter int          PORT_COUNT        = 16,
    parameter int          SEL_WIDTH         = 4,
    parameter int          DATA_WIDTH        = 64,
    parameter int          KEEP_WIDTH        = 8,
    parameter logic [15:0] CFG_ETH_TYPE      = 16'h8099,
    parameter bit          MAC_FILTER_ENABLE = 1'b1,
    parameter logic [47:0] LOCAL_MAC         = 48'h02_00_00_00_00_00
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    xpt_cfg_parser_if.slave                      s_eth,
    output logic [PORT_COUNT*SEL_WIDTH-1:0]      select,
    output logic                                 select_update,
    output logic                                 stat_cfg_good,
    output logic                                 stat_cfg_bad
);

    localparam int          CNT_W     = $clog2(PORT_COUNT + 1);
    localparam int          MAP_W     = PORT_COUNT * SEL_WIDTH;
    localparam logic [47:0] c_BCAST   = {48{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    function automatic logic [MAP_W-1:0] f_identity();
        logic [MAP_W-1:0] v;
        v = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            v[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(i);
        end
        return v;
    endfunction

    state_t             r_state;
    logic [MAP_W-1:0]   r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [MAP_W-1:0]   w_shadow_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_err_nxt;
    logic               w_hdr_match;
    logic               w_beat;
    logic               w_commit_ok;
    logic [7:0]         w_byte;
    int                 w_pop;
    int                 w_idx;
    int                 w_sum;

    // Ready lines are held low while reset is asserted, not only after it.
    assign s_eth.s_eth_hdr_ready           = rst_n && (r_state == ST_IDLE);
    assign s_eth.s_eth_payload_axis_tready = rst_n && (r_state == ST_PAYLOAD || r_state == ST_DROP);

    assign w_beat      = s_eth.s_eth_payload_axis_tvalid && s_eth.s_eth_payload_axis_tready;
    assign w_hdr_match = (s_eth.s_eth_type == CFG_ETH_TYPE) &&
                         (!MAC_FILTER_ENABLE ||
                          s_eth.s_eth_dest_mac == LOCAL_MAC ||
                          s_eth.s_eth_dest_mac == c_BCAST);

    // Shadow/counter/error as they will stand after the current beat lands.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_err_nxt    = r_err;
        w_pop        = 0;
        w_idx        = 0;
        w_byte       = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (s_eth.s_eth_payload_axis_tkeep[k]) begin
                w_pop  = w_pop + 1;
                w_idx  = int'(r_cnt) + k;
                w_byte = s_eth.s_eth_payload_axis_tdata[k*8 +: 8];
                if (w_idx < PORT_COUNT) begin
                    w_shadow_nxt[w_idx*SEL_WIDTH +: SEL_WIDTH] = w_byte[SEL_WIDTH-1:0];
                    if (int'(w_byte) >= PORT_COUNT) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
        end
        w_sum     = int'(r_cnt) + w_pop;
        w_cnt_nxt = (w_sum >= PORT_COUNT) ? CNT_W'(PORT_COUNT) : CNT_W'(w_sum);
    end

    assign w_commit_ok = !w_err_nxt && !s_eth.s_eth_payload_axis_tuser &&
                         (w_cnt_nxt == CNT_W'(PORT_COUNT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_shadow      <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            select        <= f_identity();
            select_update <= 1'b0;
            stat_cfg_good <= 1'b0;
            stat_cfg_bad  <= 1'b0;
        end else begin
            select_update <= 1'b0;
            stat_cfg_good <= 1'b0;
            stat_cfg_bad  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_eth.s_eth_hdr_valid) begin
                        if (w_hdr_match) begin
                            r_state <= ST_PAYLOAD;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_beat) begin
                        r_shadow <= w_shadow_nxt;
                        r_cnt    <= w_cnt_nxt;
                        r_err    <= w_err_nxt;
                        if (s_eth.s_eth_payload_axis_tlast) begin
                            r_state <= ST_IDLE;
                            if (w_commit_ok) begin
                                select        <= w_shadow_nxt;
                                select_update <= 1'b1;
                                stat_cfg_good <= 1'b1;
                            end else begin
                                stat_cfg_bad  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_beat && s_eth.s_eth_payload_axis_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xpt_cfg_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xpt_cfg_parser : random config frames checked against a map model      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_xpt_cfg_parser;

    localparam int          PC    = 16;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_00;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam int          TMO   = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] sel;
    logic        upd, good, bad;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_map[PC];
    logic [7:0]  frame_q[$];

    always #5 clk = ~clk;

    xpt_cfg_parser_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) bus ();

    xpt_cfg_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_eth         (bus.slave),
        .select        (sel),
        .select_update (upd),
        .stat_cfg_good (good),
        .stat_cfg_bad  (bad)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_map();
        logic [63:0] v;
        for (int i = 0; i < PC; i++) v[i*4 +: 4] = 4'(exp_map[i]);
        return v;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < PC; i++) exp_map[i] = i;
    endtask

    task automatic clear_inputs();
        bus.s_eth_hdr_valid           = 1'b0;
        bus.s_eth_dest_mac            = '0;
        bus.s_eth_src_mac             = '0;
        bus.s_eth_type                = '0;
        bus.s_eth_payload_axis_tdata  = '0;
        bus.s_eth_payload_axis_tkeep  = '0;
        bus.s_eth_payload_axis_tvalid = 1'b0;
        bus.s_eth_payload_axis_tlast  = 1'b0;
        bus.s_eth_payload_axis_tuser  = 1'b0;
    endtask

    task automatic drive_hdr(input logic [15:0] t, input logic [47:0] d, output bit ok);
        int n = 0;
        bus.s_eth_type      = t;
        bus.s_eth_dest_mac  = d;
        bus.s_eth_src_mac   = {16'h0A0B, 32'($urandom)};
        bus.s_eth_hdr_valid = 1'b1;
        while (!bus.s_eth_hdr_ready && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.s_eth_hdr_ready) begin
            check("hdr_ready_timeout", 64'(bus.s_eth_hdr_ready), 64'd1);
            bus.s_eth_hdr_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.s_eth_hdr_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep,
                              input bit last, input bit user, input int gap, output bit ok);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_eth_payload_axis_tdata  = data;
        bus.s_eth_payload_axis_tkeep  = keep;
        bus.s_eth_payload_axis_tlast  = last;
        bus.s_eth_payload_axis_tuser  = user;
        bus.s_eth_payload_axis_tvalid = 1'b1;
        while (!bus.s_eth_payload_axis_tready && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.s_eth_payload_axis_tready) begin
            check("tready_timeout", 64'(bus.s_eth_payload_axis_tready), 64'd1);
            bus.s_eth_payload_axis_tvalid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.s_eth_payload_axis_tvalid = 1'b0;
        bus.s_eth_payload_axis_tlast  = 1'b0;
        bus.s_eth_payload_axis_tuser  = 1'b0;
        ok = 1'b1;
    endtask

    // Sends frame_q as one frame and checks the outcome against the model.
    task automatic run_frame(input logic [15:0] t, input logic [47:0] d,
                             input bit user, input int max_gap);
        bit          ok;
        bit          acc;
        bit          good_f;
        int          len;
        int          nbeats;
        logic [63:0] data;
        logic [7:0]  keep;

        len    = frame_q.size();
        acc    = (t == 16'h8099) && (d == LMAC || d == BCAST);
        good_f = (len >= PC) && !user;
        for (int i = 0; i < PC && i < len; i++) if (frame_q[i] >= 8'(PC)) good_f = 1'b0;

        drive_hdr(t, d, ok);
        if (!ok) return;
        nbeats = (len + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            data = '0;
            keep = '0;
            for (int l = 0; l < 8; l++) begin
                if (b*8 + l < len) begin
                    data[l*8 +: 8] = frame_q[b*8 + l];
                    keep[l]        = 1'b1;
                end
            end
            drive_beat(data, keep, b == nbeats-1, user && (b == nbeats-1),
                       int'($urandom_range(0, max_gap)), ok);
            if (!ok) return;
        end

        if (acc && good_f) for (int i = 0; i < PC; i++) exp_map[i] = int'(frame_q[i]);
        check("select",        sel,                       pack_map());
        check("select_update", 64'(upd),                  64'(acc && good_f));
        check("stat_cfg_good", 64'(good),                 64'(acc && good_f));
        check("stat_cfg_bad",  64'(bad),                  64'(acc && !good_f));
        check("hdr_ready_next",64'(bus.s_eth_hdr_ready),  64'd1);
        @(posedge clk); #1;
        check("pulses_clear",  64'({upd, good, bad}),     64'd0);
    endtask

    task automatic load_ref_frame();
        frame_q.delete();
        for (int i = 0; i < PC; i++) frame_q.push_back(8'(15 - i));
        for (int i = 0; i < 16; i++) frame_q.push_back(8'h00);
    endtask

    initial begin
        bit          ok;
        int          perm[PC];
        int          j;
        int          tmp;
        logic [15:0] t;
        logic [47:0] d;

        clear_inputs();
        set_identity();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_ready",  64'(bus.s_eth_hdr_ready),           64'd0);
        check("rst_tready",     64'(bus.s_eth_payload_axis_tready), 64'd0);
        check("rst_select",     sel,                                64'hFEDC_BA98_7654_3210);
        check("rst_pulses",     64'({upd, good, bad}),              64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("hdr_ready_after_rst", 64'(bus.s_eth_hdr_ready),      64'd1);

        // Reference reversed map with two padding beats
        load_ref_frame();
        run_frame(16'h8099, LMAC, 1'b0, 0);
        check("ref_map", sel, 64'h0123_4567_89AB_CDEF);

        // Out-of-range select byte
        load_ref_frame();
        frame_q[5] = 8'h10;
        run_frame(16'h8099, LMAC, 1'b0, 0);

        // Frame error flag on tlast
        load_ref_frame();
        run_frame(16'h8099, LMAC, 1'b0 | 1'b1, 0);

        // Too short: only 8 bytes
        frame_q.delete();
        for (int i = 0; i < 8; i++) frame_q.push_back(8'(i));
        run_frame(16'h8099, LMAC, 1'b0, 0);

        // Wrong EtherType, then filtered destination
        load_ref_frame();
        frame_q[0] = 8'h03;
        run_frame(16'h0800, LMAC, 1'b0, 1);
        run_frame(16'h8099, 48'h02_00_00_00_00_01, 1'b0, 1);

        // Broadcast with a random permutation, short last beat
        for (int i = 0; i < PC; i++) perm[i] = i;
        for (int i = PC-1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        frame_q.delete();
        for (int i = 0; i < PC; i++) frame_q.push_back(8'(perm[i]));
        for (int i = 0; i < 3; i++) frame_q.push_back(8'hAA);
        run_frame(16'h8099, BCAST, 1'b0, 3);

        // Randomized frames with tvalid gaps
        for (int f = 0; f < 60; f++) begin
            t = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h8099;
            case ($urandom_range(0, 3))
                0:       d = LMAC;
                1:       d = BCAST;
                2:       d = 48'h02_00_00_00_00_01;
                default: d = LMAC;
            endcase
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(8, 40)); i++) begin
                if ($urandom_range(0, 40) == 0) frame_q.push_back(8'($urandom));
                else                            frame_q.push_back(8'($urandom_range(0, 15)));
            end
            run_frame(t, d, $urandom_range(0, 9) == 0, 3);
        end

        // Reset in the middle of a payload
        drive_hdr(16'h8099, LMAC, ok);
        if (ok) drive_beat(64'h0706_0504_0302_0100, 8'hFF, 1'b0, 1'b0, 0, ok);
        rst_n = 1'b0;
        set_identity();
        @(posedge clk); #1;
        check("midrst_select",  sel,                                pack_map());
        check("midrst_update",  64'(upd),                           64'd0);
        check("midrst_tready",  64'(bus.s_eth_payload_axis_tready), 64'd0);
        check("midrst_hdr",     64'(bus.s_eth_hdr_ready),           64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_hdr_after", 64'(bus.s_eth_hdr_ready),         64'd1);
        check("midrst_no_update", 64'(upd),                         64'd0);

        load_ref_frame();
        run_frame(16'h8099, BCAST, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
